// File: rtl/alarm_clock_core.sv
// BCD HH:MM:SS timekeeper with N_ALARM edge-triggered alarm channels (ring / timeout / ack / snooze).
// Define ALARM_SNOOZE_EN to build the snooze state and counter; otherwise the snooze input is ignored.

module alarm_chan #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        wr,
  input  logic        wr_ok,
  input  logic [12:0] wr_time,
  input  logic        wr_en,
  input  logic        ack,
  input  logic        snooze,
  input  logic        min_tick,
  input  logic [12:0] nxt_hm,
  output logic        ring_nxt,
  output logic        ring
);
  localparam int RC_W = $clog2(RING_SECS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
    , SNOOZE = 2'd2
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [12:0]     atime, atime_nxt;
  logic            aen, aen_nxt;
  logic [RC_W-1:0] rcnt, rcnt_nxt;
  logic            trig;

`ifdef ALARM_SNOOZE_EN
  localparam int SC_W = $clog2(SNOOZE_MIN * 60 + 1);
  logic [SC_W-1:0] scnt, scnt_nxt;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Edge-triggered: only the tick that rolls seconds to :00 can match.
  assign trig = aen & min_tick & (nxt_hm == atime);

  always_comb begin
    state_nxt = state;
    atime_nxt = atime;
    aen_nxt   = aen;
    rcnt_nxt  = rcnt;
`ifdef ALARM_SNOOZE_EN
    scnt_nxt  = scnt;
`endif
    if (wr) begin
      state_nxt = IDLE;
      if (wr_ok) begin
        atime_nxt = wr_time;
        aen_nxt   = wr_en;
      end
    end else if (ack) begin
      state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
    end else if (snooze && state == RINGING) begin
      state_nxt = SNOOZE;
      scnt_nxt  = SC_W'(SNOOZE_MIN * 60);
`endif
    end else if (trig) begin
      state_nxt = RINGING;
      rcnt_nxt  = '0;
    end else if (tick) begin
      case (state)
        RINGING: begin
          if (rcnt == RC_W'(RING_SECS - 1)) state_nxt = IDLE;
          else                              rcnt_nxt  = rcnt + 1'b1;
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (scnt <= SC_W'(1)) begin
            state_nxt = RINGING;
            rcnt_nxt  = '0;
            scnt_nxt  = '0;
          end else begin
            scnt_nxt = scnt - 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ring_nxt = (state_nxt == RINGING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      atime <= '0;
      aen   <= 1'b0;
      rcnt  <= '0;
      ring  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      scnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      atime <= atime_nxt;
      aen   <= aen_nxt;
      rcnt  <= rcnt_nxt;
      ring  <= ring_nxt;
`ifdef ALARM_SNOOZE_EN
      scnt  <= scnt_nxt;
`endif
    end
  end
endmodule

module alarm_clock_core #(
  parameter int N_ALARM    = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_1hz,
  input  logic                       load,
  input  logic [13:0]                set_time,
  input  logic                       alm_wr,
  input  logic [$clog2(N_ALARM)-1:0] alm_sel,
  input  logic [13:0]                alm_time,
  input  logic                       alm_en,
  input  logic                       alm_ack,
  input  logic                       snooze,
  output logic [19:0]                time_bcd,
  output logic [N_ALARM-1:0]         ring,
  output logic                       ring_any
);
  localparam int SEL_W = $clog2(N_ALARM);

  logic [1:0] hd1, n_hd1;
  logic [3:0] hd0, n_hd0, md0, n_md0, sd0, n_sd0;
  logic [2:0] md1, n_md1, sd1, n_sd1;
  logic       min_tick, alm_ok;
  logic [N_ALARM-1:0] ring_nxt;

  // Fields packed right-aligned: md0[3:0] md1[6:4] hd0[10:7] hd1[12:11]; bit 13 must be zero.
  function automatic logic bcd_ok(input logic [13:0] t);
    return !t[13] && (t[3:0] <= 4'd9) && (t[6:4] <= 3'd5) && (t[10:7] <= 4'd9) &&
           ((t[12:11] < 2'd2) || (t[12:11] == 2'd2 && t[10:7] <= 4'd3));
  endfunction

  assign time_bcd = {hd1, hd0, md1, md0, sd1, sd0};
  assign alm_ok   = bcd_ok(alm_time);
  assign min_tick = tick_1hz & ~load & (sd0 == 4'd9) & (sd1 == 3'd5);

  always_comb begin
    {n_hd1, n_hd0, n_md1, n_md0, n_sd1, n_sd0} = {hd1, hd0, md1, md0, sd1, sd0};
    if (sd0 != 4'd9) n_sd0 = sd0 + 1'b1;
    else begin
      n_sd0 = '0;
      if (sd1 != 3'd5) n_sd1 = sd1 + 1'b1;
      else begin
        n_sd1 = '0;
        if (md0 != 4'd9) n_md0 = md0 + 1'b1;
        else begin
          n_md0 = '0;
          if (md1 != 3'd5) n_md1 = md1 + 1'b1;
          else begin
            n_md1 = '0;
            if (hd1 == 2'd2 && hd0 == 4'd3) begin
              n_hd1 = '0;
              n_hd0 = '0;
            end else if (hd0 == 4'd9) begin
              n_hd0 = '0;
              n_hd1 = hd1 + 1'b1;
            end else begin
              n_hd0 = hd0 + 1'b1;
            end
          end
        end
      end
    end
  end

  // A load, even a rejected one, swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      {hd1, hd0, md1, md0, sd1, sd0} <= '0;
    end else if (load) begin
      if (bcd_ok(set_time)) begin
        {hd1, hd0, md1, md0} <= set_time[12:0];
        {sd1, sd0}           <= '0;
      end
    end else if (tick_1hz) begin
      {hd1, hd0, md1, md0, sd1, sd0} <= {n_hd1, n_hd0, n_md1, n_md0, n_sd1, n_sd0};
    end
  end

  for (genvar i = 0; i < N_ALARM; i++) begin : g_chan
    alarm_chan #(
      .RING_SECS (RING_SECS),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_1hz),
      .wr      (alm_wr && (alm_sel == SEL_W'(i))),
      .wr_ok   (alm_ok),
      .wr_time (alm_time[12:0]),
      .wr_en   (alm_en),
      .ack     (alm_ack),
      .snooze  (snooze),
      .min_tick(min_tick),
      .nxt_hm  ({n_hd1, n_hd0, n_md1, n_md0}),
      .ring_nxt(ring_nxt[i]),
      .ring    (ring[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) ring_any <= 1'b0;
    else     ring_any <= |ring_nxt;
  end
endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench for alarm_clock_core: day wrap, load/alarm validation, trigger, timeout, ack, snooze, reset.
module tb_alarm_clock_core;
  logic        clk = 1'b0;
  logic        rst, tick_1hz, load, alm_wr, alm_en, alm_ack, snooze;
  logic [13:0] set_time, alm_time;
  logic [1:0]  alm_sel;
  logic [19:0] time_bcd;
  logic [3:0]  ring;
  logic        ring_any;
  int          n_chk = 0, n_err = 0;
  logic        ring_seen;

  alarm_clock_core #(.N_ALARM(4), .RING_SECS(60), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .load(load), .set_time(set_time),
    .alm_wr(alm_wr), .alm_sel(alm_sel), .alm_time(alm_time), .alm_en(alm_en),
    .alm_ack(alm_ack), .snooze(snooze), .time_bcd(time_bcd), .ring(ring), .ring_any(ring_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] tt(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [13:0] st(input int h, input int m);
    return {1'b0, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    tick_1hz = 1'b1;
    repeat (n) step();
    tick_1hz = 1'b0;
  endtask

  task automatic do_load(input int h, input int m);
    set_time = st(h, m); load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_wr(input int ch, input int h, input int m, input logic en);
    alm_sel = 2'(ch); alm_time = st(h, m); alm_en = en; alm_wr = 1'b1;
    step();
    alm_wr = 1'b0;
  endtask

  task automatic do_ack();
    alm_ack = 1'b1;
    step();
    alm_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 0; load = 0; alm_wr = 0; alm_en = 0; alm_ack = 0; snooze = 0;
    set_time = '0; alm_time = '0; alm_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_time", time_bcd, 20'h0);
    chk("rst_ring", ring, 4'b0);
    chk("rst_any", ring_any, 1'b0);

    // Full day: wrap at 23:59:59, no alarms enabled.
    ring_seen = 1'b0;
    tick_1hz = 1'b1;
    for (int i = 0; i < 86399; i++) begin
      step();
      if (ring_any || ring != 0) ring_seen = 1'b1;
    end
    chk("day_235959", time_bcd, tt(23, 59, 59));
    step();
    tick_1hz = 1'b0;
    chk("day_wrap", time_bcd, tt(0, 0, 0));
    chk("day_no_ring", ring_seen, 1'b0);

    // Trigger on ch2 and auto-stop after 60 ticks.
    do_load(12, 34);
    chk("load_1234", time_bcd, tt(12, 34, 0));
    do_wr(2, 12, 35, 1'b1);
    ticks(59);
    chk("pre_trig_time", time_bcd, tt(12, 34, 59));
    chk("pre_trig_ring", ring, 4'b0);
    ticks(1);
    chk("trig_time", time_bcd, tt(12, 35, 0));
    chk("trig_ring", ring, 4'b0100);
    chk("trig_any", ring_any, 1'b1);
    ticks(59);
    chk("ring_59", ring, 4'b0100);
    ticks(1);
    chk("timeout_ring", ring, 4'b0);
    chk("timeout_any", ring_any, 1'b0);

    // Rejected load, load beating tick, rejected alarm write.
    do_load(25, 0);
    chk("bad_load", time_bcd, tt(12, 36, 0));
    set_time = st(8, 0); load = 1'b1; tick_1hz = 1'b1;
    step();
    load = 1'b0; tick_1hz = 1'b0;
    chk("load_vs_tick", time_bcd, tt(8, 0, 0));
    do_wr(2, 12, 60, 1'b1);
    do_load(12, 34);
    ticks(60);
    chk("bad_wr_kept", ring, 4'b0100);
    do_ack();
    chk("ack_ch2", ring, 4'b0);

    // Two channels together, ack, then one disabled.
    do_wr(0, 6, 0, 1'b1);
    do_wr(3, 6, 0, 1'b1);
    do_load(5, 59);
    ticks(60);
    chk("dual_ring", ring, 4'b1001);
    do_ack();
    chk("dual_ack", ring, 4'b0);
    chk("dual_ack_any", ring_any, 1'b0);
    do_wr(0, 6, 0, 1'b0);
    do_load(5, 59);
    ticks(60);
    chk("ch0_disabled", ring, 4'b1000);
    do_ack();

    // Write + ack on a ringing channel: idle, new time stored.
    do_wr(1, 7, 0, 1'b1);
    do_load(6, 59);
    ticks(60);
    chk("ch1_ring", ring, 4'b0010);
    alm_sel = 2'd1; alm_time = st(7, 30); alm_en = 1'b1; alm_wr = 1'b1; alm_ack = 1'b1;
    step();
    alm_wr = 1'b0; alm_ack = 1'b0;
    chk("wr_ack_idle", ring, 4'b0);
    do_load(7, 29);
    ticks(60);
    chk("ch1_new_time", ring, 4'b0010);

`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1; step(); snooze = 1'b0;
    chk("snooze_off", ring, 4'b0);
    ticks(299);
    chk("snooze_299", ring, 4'b0);
    ticks(1);
    chk("snooze_wake", ring, 4'b0010);
    snooze = 1'b1; alm_ack = 1'b1; step(); snooze = 1'b0; alm_ack = 1'b0;
    chk("snz_ack_ring", ring, 4'b0);
    ticks(300);
    chk("snz_ack_idle", ring, 4'b0);
    do_load(7, 29);
    ticks(60);
    chk("ring_again", ring, 4'b0010);
    snooze = 1'b1; step(); snooze = 1'b0;
    ticks(10);
`else
    snooze = 1'b1; step(); snooze = 1'b0;
    chk("snooze_ignored", ring, 4'b0010);
`endif

    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_time", time_bcd, 20'h0);
    chk("mid_rst_ring", ring, 4'b0);
    chk("mid_rst_any", ring_any, 1'b0);
    do_load(7, 29);
    ticks(60);
    chk("post_rst_disabled", ring, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
